framebuffer_arbiter: RTL

Shares the single framebuffer write port among `N_REQ` pixel producers (plotters, test pattern generators, overlay writers) using round-robin arbitration, and adds a hardware frame-clear sequencer that fills the whole frame with one colour. Sits between the producers and the framebuffer memory write port. All framebuffer-side outputs are registered.

---
 rtl/framebuffer_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/framebuffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_arbiter
// Purpose  : Round-robin sharing of one framebuffer write port among N_REQ
//            pixel producers, plus a hardware frame-clear sequencer that
//            sweeps the whole frame with a single colour.
// Revision : 1.0 - initial release
// ============================================================================
module framebuffer_arbiter #(
   parameter int N_REQ   = 2,
   parameter int HEIGHT  = 480,
   parameter int WIDTH   = 640,
   parameter int ADDR_W  = 19,
   parameter int PIXEL_W = 32
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*ADDR_W-1:0]    req_address,
   input  logic [N_REQ*PIXEL_W-1:0]   req_data,
   output logic [N_REQ-1:0]           req_ready,
   input  logic                       clear_start,
   input  logic [PIXEL_W-1:0]         clear_color,
   output logic                       clear_busy,
   output logic                       clear_done,
   output logic                       fb_we,
   output logic [ADDR_W-1:0]          fb_address,
   output logic [PIXEL_W-1:0]         fb_data,
   output logic                       drop
);

   localparam int TOTAL = HEIGHT * WIDTH;
   localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int LG_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(TOTAL - 1);
   localparam logic [ADDR_W:0]  TOTAL_EXT = (ADDR_W + 1)'(TOTAL);
   // A one-pixel frame finishes on the very first clear write.
   localparam logic             ONE_PIX   = (TOTAL == 1);

   typedef enum logic [0:0] {
      ST_ARB   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [LG_W-1:0]     last_grant;
   logic [CNT_W-1:0]    sweep_cnt;
   logic [CNT_W-1:0]    sweep_cnt_inc;
   logic [PIXEL_W-1:0]  clear_color_q;

   logic [N_REQ-1:0]    grant;
   logic [LG_W-1:0]     winner;
   logic                hit;
   logic [ADDR_W-1:0]   sel_address;
   logic [PIXEL_W-1:0]  sel_data;
   logic                in_range;
   logic                sweep_last;

   // Round-robin search starting just after the previous winner; a clear
   // request or an active sweep blocks every requester.
   always_comb begin
      int idx;
      idx         = 0;
      grant       = '0;
      winner      = last_grant;
      hit         = 1'b0;
      sel_address = '0;
      sel_data    = '0;
      if (state == ST_ARB && !clear_start) begin
         for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!hit && req_valid[idx]) begin
               hit         = 1'b1;
               grant[idx]  = 1'b1;
               winner      = LG_W'(idx);
               sel_address = req_address[idx*ADDR_W +: ADDR_W];
               sel_data    = req_data[idx*PIXEL_W +: PIXEL_W];
            end
         end
      end
   end

   assign req_ready     = grant;
   assign in_range      = ({1'b0, sel_address} < TOTAL_EXT);
   assign sweep_cnt_inc = sweep_cnt + 1'b1;
   assign sweep_last    = (sweep_cnt == LAST_PIX);

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_ARB;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: enter CLEAR on a request, leave once the last pixel's write
   // has been on the port for its cycle.
   always_comb begin
      state_next = state;
      if (state == ST_ARB) begin
         if (clear_start) begin
            state_next = ST_CLEAR;
         end
      end else begin
         if (sweep_last) begin
            state_next = ST_ARB;
         end
      end
   end

   // Registered write port. The first clear write is loaded on the same edge
   // that accepts clear_start, so sweep_cnt always equals the address that is
   // currently presented on fb_address while sweeping.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fb_we         <= 1'b0;
         fb_address    <= '0;
         fb_data       <= '0;
         clear_busy    <= 1'b0;
         clear_done    <= 1'b0;
         drop          <= 1'b0;
         last_grant    <= LG_W'(N_REQ - 1);
         sweep_cnt     <= '0;
         clear_color_q <= '0;
      end else if (state == ST_ARB) begin
         if (clear_start) begin
            clear_color_q <= clear_color;
            sweep_cnt     <= '0;
            fb_we         <= 1'b1;
            fb_address    <= '0;
            fb_data       <= clear_color;
            clear_busy    <= 1'b1;
            clear_done    <= ONE_PIX;
            drop          <= 1'b0;
         end else if (hit) begin
            last_grant <= winner;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
            if (in_range) begin
               fb_we      <= 1'b1;
               fb_address <= sel_address;
               fb_data    <= sel_data;
               drop       <= 1'b0;
            end else begin
               fb_we <= 1'b0;
               drop  <= 1'b1;
            end
         end else begin
            fb_we      <= 1'b0;
            drop       <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
         end
      end else begin
         drop <= 1'b0;
         if (sweep_last) begin
            fb_we      <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
         end else begin
            sweep_cnt  <= sweep_cnt_inc;
            fb_we      <= 1'b1;
            fb_address <= ADDR_W'(sweep_cnt_inc);
            fb_data    <= clear_color_q;
            clear_busy <= 1'b1;
            clear_done <= (sweep_cnt_inc == LAST_PIX);
         end
      end
   end

endmodule
`default_nettype wire
